// File: rtl/nibble_serializer_if.sv
// Handshake bundle for nibble_serializer: parallel word in, qualified nibbles out.
// The serializer uses the slave modport; the word source / nibble sink uses master.
interface nibble_serializer_if #(
  parameter int NIBBLES = 2
) ();
  logic [4*NIBBLES-1:0] data_in;
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           nib_out;
  logic                 shift_en;
  logic                 out_ready;
  logic                 last;
  logic                 busy;

  modport master (
    output data_in, in_valid, out_ready,
    input  in_ready, nib_out, shift_en, last, busy
  );

  modport slave (
    input  data_in, in_valid, out_ready,
    output in_ready, nib_out, shift_en, last, busy
  );
endinterface

// File: rtl/nibble_serializer.sv
// Serializes a 4*NIBBLES-bit word into nibbles, least-significant first, with a
// one-word holding buffer so a new word can be handed over while the current one drains.
module nibble_serializer #(
  parameter int NIBBLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  nibble_serializer_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t        state_q;
  logic [W-1:0]  sreg_q;
  logic [W-1:0]  hold_q;
  logic [CW-1:0] cnt_q;
  logic          hold_full_q;

  logic accept_s;
  logic xfer_s;
  logic final_s;

  assign accept_s = bus.in_valid & ~hold_full_q;
  assign xfer_s   = (state_q == SEND) & bus.out_ready;
  assign final_s  = (cnt_q == CNT_LAST);

  // Word loading, holding-buffer management and nibble shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      hold_q      <= '0;
      cnt_q       <= '0;
      hold_full_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            sreg_q  <= bus.data_in;
            cnt_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (xfer_s && final_s) begin
            cnt_q <= '0;
            // A buffered word always goes ahead of one arriving in this cycle.
            if (hold_full_q) begin
              sreg_q      <= hold_q;
              hold_full_q <= 1'b0;
            end else if (accept_s) begin
              sreg_q <= bus.data_in;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            if (xfer_s) begin
              sreg_q <= {4'h0, sreg_q[W-1:4]};
              cnt_q  <= cnt_q + 1'b1;
            end
            if (accept_s) begin
              hold_q      <= bus.data_in;
              hold_full_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.nib_out  = sreg_q[3:0];
  assign bus.shift_en = (state_q == SEND);
  assign bus.last     = (state_q == SEND) & final_s;
  assign bus.busy     = (state_q == SEND) | hold_full_q;
  assign bus.in_ready = ~hold_full_q;
endmodule

// File: doc/nibble_serializer.md
# nibble_serializer

Transmit side of the 4-bit nibble link. The block accepts a parallel word of `4*NIBBLES` bits and emits it as 4-bit nibbles, least-significant nibble first. Each nibble is qualified by `shift_en`. The order matches the receiving shift register, which shifts each nibble in at the top. After `NIBBLES` shifts, the receiver therefore holds the original word unchanged. A one-entry holding buffer lets the upstream hand over the next word while the current one drains, so the link runs at one nibble per cycle with no bubbles.

## Interface
- `NIBBLES`, default 2: nibbles per word. Input width is `4*NIBBLES`. Legal values are 2 to 16.
- `clk`  in  1  sole clock; everything is sampled on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  `4*NIBBLES`  word to transmit.
- `in_valid`  in  1  `data_in` is valid.
- `in_ready`  out  1  block can accept a word. A transfer happens when `in_valid & in_ready` at the clock edge.
- `nib_out`  out  4  current nibble.
- `shift_en`  out  1  `nib_out` is valid; this drives the receiver's shift enable.
- `out_ready`  in  1  downstream takes the nibble. A transfer happens when `shift_en & out_ready`. Tie `out_ready` to 1 for a free-running receiver.
- `last`  out  1  current nibble is the final nibble of its word.
- `busy`  out  1  a word is in flight or buffered.

## Operation
**Internal state**
- `sreg`: `4*NIBBLES` bits.
- `cnt`: `clog2(NIBBLES)` bits.
- `hold`: `4*NIBBLES` bits, with flag `hold_full`.
- FSM with states IDLE and SEND.

**Output decode**
- `nib_out` = `sreg[3:0]`.
- `shift_en` = (state == SEND).
- `last` = `shift_en & (cnt == NIBBLES-1)`.
- `busy` = (state == SEND) | `hold_full`.
- `in_ready` = `!hold_full`.

**Accept in IDLE:** `sreg <= data_in`, `cnt <= 0`, go to SEND.

**Accept in SEND, non-final transfer or no transfer:** `hold <= data_in`, `hold_full <= 1`.

**Transfer, not last:** `sreg <= sreg >> 4` (zero-fill at the top), `cnt <= cnt+1`.

**Transfer, last:**
- If `hold_full`: `sreg <= hold`, `hold_full <= 0`, `cnt <= 0`, stay in SEND.
- Else if an accept happens in the same cycle: `sreg <= data_in`, `cnt <= 0`, stay in SEND. The word bypasses `hold`.
- Else: go to IDLE, `cnt <= 0`.

**Backpressure:** while `shift_en & !out_ready`, `nib_out`, `last` and `cnt` hold their values. `shift_en` never drops before its transfer completes.

**Ignored inputs**
- `in_valid` is ignored while `in_ready = 0`.
- `out_ready` is ignored while `shift_en = 0`.

**Ordering:** words go out strictly in acceptance order. None is dropped or duplicated.

## Timing
- **Reset** (`rst_n` low, asynchronous):
  - State goes to IDLE; `sreg`, `hold` and `cnt` go to 0; `hold_full` goes to 0.
  - Output values in reset: `nib_out` = 0, `shift_en` = 0, `last` = 0, `busy` = 0, `in_ready` = 1.
  - Inputs have no effect while `rst_n` is low.
  - A word in flight or buffered when reset asserts is discarded. No partial tail is emitted after release.
- **Latency:** a word accepted at edge N presents its first nibble (`shift_en` = 1) from edge N to edge N+1.
  - With `out_ready` held at 1, nibble k is transferred at edge N+1+k.
  - The last nibble is transferred at edge N+NIBBLES.
- **Throughput:** with `out_ready` = 1 and `in_valid` held high, `shift_en` stays 1 continuously. Output rate is one nibble per cycle, one word per `NIBBLES` cycles.
- **`in_ready` pattern:** `in_ready` drops for exactly the cycles that `hold_full` is set, one cycle after each accept made during SEND.
- **Combinational paths:** no combinational path from any input to any output. All outputs are decoded from registers only.

## Test plan
- **Single word:** reset, then present `data_in` = 0xA5 with `out_ready` = 1.
  - Required: `nib_out` = 5 then A on consecutive cycles.
  - `last` = 1 only on A.
  - `busy` = 0 afterwards.
- **Loopback:** connect `nib_out`/`shift_en` to the receiving shift register (`data_in`/`shift_en`), send 0x3C.
  - Required: the receiver output reads 0x3C one edge after the transfer of `last`.
- **Back-to-back:** hold `in_valid` high with words 0x12, 0x34, 0x56 and `out_ready` = 1.
  - Required: nibbles 2,1,4,3,6,5 on 6 consecutive cycles with no gap.
  - `in_ready` = 0 during each second-nibble cycle.
- **Backpressure:** send 0x9E, hold `out_ready` = 0 for 3 cycles during the first nibble.
  - Required: `nib_out` = E and `shift_en` = 1 stay stable throughout.
  - Then E, 9 are transferred; no nibble is lost or repeated.
- **Reset mid-word:** accept 0x77, queue 0x88, assert `rst_n` low after the first nibble transfers.
  - Required: all outputs return to their reset values immediately.
  - After release nothing is emitted until a new accept.
  - A new word 0x41 yields 1, 4.
- **NIBBLES = 4:** send 0xBEEF.
  - Required: nibbles F, E, E, B, with `last` = 1 only on B.
